// File: rtl/serial_subtractor_nbit_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_nbit_if #(
    parameter int unsigned BIT_WIDTH = 4
);
    logic                 start;
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic                 borrow_in;
    logic                 busy;
    logic                 done;
    logic [BIT_WIDTH-1:0] difference;
    logic                 underflow;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, difference, underflow
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, difference, underflow
    );
endinterface

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial a - b - borrow_in: one full-subtractor cell plus a borrow flop,
// LSB first, with a start/busy/done handshake.
module serial_subtractor_nbit #(
    parameter int unsigned BIT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_subtractor_nbit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(BIT_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0] a_q, a_d;
    logic [BIT_WIDTH-1:0] b_q, b_d;
    logic [BIT_WIDTH-2:0] res_q, res_d;
    logic [BIT_WIDTH-1:0] diff_q, diff_d;
    logic                 br_q, br_d;
    logic                 uf_q, uf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 a_bit, b_bit, d_bit, br_next;
    logic [BIT_WIDTH-1:0] res_w;

    // Full-subtractor cell on the current LSBs
    always_comb begin
        a_bit   = a_q[0];
        b_bit   = b_q[0];
        d_bit   = a_bit ^ b_bit ^ br_q;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        res_w   = {d_bit, res_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        diff_d  = diff_q;
        uf_d    = uf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.borrow_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // res_w holds all bits so far; the oldest drops off the bottom
                res_d = res_w[BIT_WIDTH-1:1];
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIT_WIDTH - 1)) begin
                    diff_d  = res_w;
                    uf_d    = br_next;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            uf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            uf_q    <= uf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Flag undefined operand bits at the moment they are captured
    always @(posedge clk) begin
        if (!rst && state_q == IDLE && bus.start) begin
            for (int i = 0; i < int'(BIT_WIDTH); i++) begin
                if ($isunknown(bus.a[i])) $error("serial_subtractor_nbit: X/Z on a[%0d]", i);
                if ($isunknown(bus.b[i])) $error("serial_subtractor_nbit: X/Z on b[%0d]", i);
            end
            if ($isunknown(bus.borrow_in)) $error("serial_subtractor_nbit: X/Z on borrow_in[0]");
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.difference = diff_q;
    assign bus.underflow  = uf_q;
endmodule
